// File: rtl/nts_api_pkg.sv
// Shared constants for the NTS register bridge: region map, FSM states, slave indices.
package nts_api_pkg;

  localparam int unsigned NUM_SLAVES = 7;

  typedef enum logic [2:0] {
    SLV_ENGINE  = 3'd0,
    SLV_CLOCK   = 3'd1,
    SLV_COOKIE  = 3'd2,
    SLV_KEYMEM  = 3'd3,
    SLV_DEBUG   = 3'd4,
    SLV_PARSER  = 3'd5,
    SLV_NTPAUTH = 3'd6
  } slave_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Inclusive region bounds, packed so element [i] matches slave_t index i.
  localparam logic [NUM_SLAVES-1:0][11:0] REGION_BASE = {
    12'h300, 12'h200, 12'h180, 12'h080, 12'h020, 12'h010, 12'h000
  };
  localparam logic [NUM_SLAVES-1:0][11:0] REGION_LIMIT = {
    12'h3FF, 12'h2FF, 12'h1FF, 12'h0FF, 12'h03F, 12'h01F, 12'h00F
  };

endpackage

// File: rtl/nts_api_decoder.sv
// Combinational decode of a 12-bit external address into a one-hot slave select and 8-bit offset.
module nts_api_decoder
  import nts_api_pkg::*;
(
  input  logic [11:0]           address,
  output logic [NUM_SLAVES-1:0] select,
  output logic [7:0]            offset
);

  logic [11:0] delta;

  // Regions never overlap, so at most one select bit can be set.
  always_comb begin
    select = '0;
    offset = '0;
    delta  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (address >= REGION_BASE[i] && address <= REGION_LIMIT[i]) begin
        select[i] = 1'b1;
        delta     = address - REGION_BASE[i];
        offset    = delta[7:0];
      end
    end
  end

endmodule

// File: rtl/nts_api.sv
// Bridge from the 12-bit external register bus to the engine's internal 8-bit slave bus.
module nts_api
  import nts_api_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_areset,
  output logic        o_busy,
  input  logic        i_external_api_cs,
  input  logic        i_external_api_we,
  input  logic [11:0] i_external_api_address,
  input  logic [31:0] i_external_api_write_data,
  output logic [31:0] o_external_api_read_data,
  output logic        o_external_api_read_data_valid,
  output logic        o_internal_api_we,
  output logic [7:0]  o_internal_api_address,
  output logic [31:0] o_internal_api_write_data,
  output logic        o_internal_engine_api_cs,
  input  logic [31:0] i_internal_engine_api_read_data,
  output logic        o_internal_clock_api_cs,
  input  logic [31:0] i_internal_clock_api_read_data,
  output logic        o_internal_cookie_api_cs,
  input  logic [31:0] i_internal_cookie_api_read_data,
  output logic        o_internal_keymem_api_cs,
  input  logic [31:0] i_internal_keymem_api_read_data,
  output logic        o_internal_debug_api_cs,
  input  logic [31:0] i_internal_debug_api_read_data,
  output logic        o_internal_parser_api_cs,
  input  logic [31:0] i_internal_parser_api_read_data,
  output logic        o_internal_ntpauth_keymem_api_cs,
  input  logic [31:0] i_internal_ntpauth_keymem_api_read_data
);

  state_t                state;
  state_t                state_next;
  logic [NUM_SLAVES-1:0] dec_select;
  logic [7:0]            dec_offset;
  logic [NUM_SLAVES-1:0] sel_r;
  logic                  we_r;
  logic [7:0]            addr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           rdata_r;
  logic [31:0]           slave_rdata;
  logic [NUM_SLAVES-1:0] cs;

  nts_api_decoder u_decoder (
    .address (i_external_api_address),
    .select  (dec_select),
    .offset  (dec_offset)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_areset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state: every accepted request runs exactly one ACCESS and one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (i_external_api_cs) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request capture; only an idle bridge accepts a new strobe.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      sel_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (state == ST_IDLE && i_external_api_cs) begin
      sel_r   <= dec_select;
      we_r    <= i_external_api_we;
      addr_r  <= dec_offset;
      wdata_r <= i_external_api_write_data;
    end
  end

  // AND-OR read mux; an unmapped access has no select bit and yields zero.
  always_comb begin
    slave_rdata = ({32{sel_r[SLV_ENGINE]}}  & i_internal_engine_api_read_data)
                | ({32{sel_r[SLV_CLOCK]}}   & i_internal_clock_api_read_data)
                | ({32{sel_r[SLV_COOKIE]}}  & i_internal_cookie_api_read_data)
                | ({32{sel_r[SLV_KEYMEM]}}  & i_internal_keymem_api_read_data)
                | ({32{sel_r[SLV_DEBUG]}}   & i_internal_debug_api_read_data)
                | ({32{sel_r[SLV_PARSER]}}  & i_internal_parser_api_read_data)
                | ({32{sel_r[SLV_NTPAUTH]}} & i_internal_ntpauth_keymem_api_read_data);
  end

  // Response capture at the closing edge of ACCESS; held until the next capture.
  always_ff @(posedge i_clk) begin
    if (i_areset)                rdata_r <= '0;
    else if (state == ST_ACCESS) rdata_r <= we_r ? '0 : slave_rdata;
  end

  // Slave selects are live only during ACCESS.
  always_comb begin
    cs = (state == ST_ACCESS) ? sel_r : '0;
  end

  assign o_busy                           = (state == ST_ACCESS);
  assign o_external_api_read_data_valid   = (state == ST_DONE);
  assign o_external_api_read_data         = rdata_r;
  assign o_internal_api_we                = we_r;
  assign o_internal_api_address           = addr_r;
  assign o_internal_api_write_data        = wdata_r;
  assign o_internal_engine_api_cs         = cs[SLV_ENGINE];
  assign o_internal_clock_api_cs          = cs[SLV_CLOCK];
  assign o_internal_cookie_api_cs         = cs[SLV_COOKIE];
  assign o_internal_keymem_api_cs         = cs[SLV_KEYMEM];
  assign o_internal_debug_api_cs          = cs[SLV_DEBUG];
  assign o_internal_parser_api_cs         = cs[SLV_PARSER];
  assign o_internal_ntpauth_keymem_api_cs = cs[SLV_NTPAUTH];

endmodule

// File: tb/tb_nts_api.sv
// Scoreboard bench for nts_api: driver pushes expected responses, monitor pops on each valid pulse.
module tb_nts_api;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        ext_cs;
  logic        ext_we;
  logic [11:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_valid;
  logic        int_we;
  logic [7:0]  int_addr;
  logic [31:0] int_wdata;
  logic [6:0]  cs;
  logic [31:0] rd [7];
  logic [31:0] parser_ram [256];

  int unsigned tests  = 0;
  int unsigned errors = 0;
  int unsigned cs_count [7];
  logic [7:0]  last_addr [7];
  logic        last_we [7];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  nts_api dut (
    .i_clk                                  (clk),
    .i_areset                               (rst),
    .o_busy                                 (busy),
    .i_external_api_cs                      (ext_cs),
    .i_external_api_we                      (ext_we),
    .i_external_api_address                 (ext_addr),
    .i_external_api_write_data              (ext_wdata),
    .o_external_api_read_data               (ext_rdata),
    .o_external_api_read_data_valid         (ext_valid),
    .o_internal_api_we                      (int_we),
    .o_internal_api_address                 (int_addr),
    .o_internal_api_write_data              (int_wdata),
    .o_internal_engine_api_cs               (cs[0]),
    .i_internal_engine_api_read_data        (rd[0]),
    .o_internal_clock_api_cs                (cs[1]),
    .i_internal_clock_api_read_data         (rd[1]),
    .o_internal_cookie_api_cs               (cs[2]),
    .i_internal_cookie_api_read_data        (rd[2]),
    .o_internal_keymem_api_cs               (cs[3]),
    .i_internal_keymem_api_read_data        (rd[3]),
    .o_internal_debug_api_cs                (cs[4]),
    .i_internal_debug_api_read_data         (rd[4]),
    .o_internal_parser_api_cs               (cs[5]),
    .i_internal_parser_api_read_data        (rd[5]),
    .o_internal_ntpauth_keymem_api_cs       (cs[6]),
    .i_internal_ntpauth_keymem_api_read_data(rd[6])
  );

  // Register-style slave models; write data is only reflected on writes.
  function automatic logic [31:0] slave_word(input logic [7:0] tag);
    logic [7:0] wd;
    wd = int_we ? int_wdata[7:0] : 8'h00;
    return {tag, 7'h0, int_we, wd, int_addr};
  endfunction

  always_comb begin
    rd[0] = slave_word(8'h0A);
    rd[1] = slave_word(8'h0B);
    rd[2] = slave_word(8'h0C);
    rd[3] = slave_word(8'h0D);
    rd[4] = slave_word(8'h0E);
    rd[5] = parser_ram[int_addr];
    rd[6] = slave_word(8'h0F);
  end

  always @(posedge clk) begin
    if (cs[5] && int_we) parser_ram[int_addr] <= int_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: response scoreboard, select sanity and per-slave select accounting.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cs_onehot_no_x", {31'h0, ($isunknown(cs) || !$onehot0(cs))}, 32'h0);
      for (int k = 0; k < 7; k++) begin
        if (cs[k] === 1'b1) begin
          cs_count[k]++;
          last_addr[k] = int_addr;
          last_we[k]   = int_we;
        end
      end
      if (ext_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'h1, 32'h0);
        else                   chk("read_data", ext_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp);
    int unsigned n;
    @(negedge clk);
    ext_cs = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    exp_q.push_back(exp);
    @(negedge clk);
    ext_cs = 1'b0;
    chk("busy_in_access", {31'h0, busy}, 32'h1);
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop_timeout", {31'h0, busy}, 32'h0);
    chk("valid_pulse", {31'h0, ext_valid}, 32'h1);
    @(negedge clk);
    chk("valid_low_after", {31'h0, ext_valid}, 32'h0);
  endtask

  initial begin
    int unsigned c2, c3, total;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) parser_ram[i] = '0;
    for (int k = 0; k < 7; k++) begin cs_count[k] = 0; last_addr[k] = '0; last_we[k] = 1'b0; end
    rst = 1'b1; ext_cs = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'h0, busy}, 32'h0);
    chk("reset_valid", {31'h0, ext_valid}, 32'h0);
    chk("reset_rdata", ext_rdata, 32'h0);
    chk("reset_cs",    {25'h0, cs}, 32'h0);
    rst = 1'b0;

    // Reads from the tagged register slaves.
    txn(1'b0, 12'h000, 32'h0, 32'h0A000000);
    txn(1'b0, 12'h005, 32'h0, 32'h0A000005);
    txn(1'b0, 12'h010, 32'hF, 32'h0B000000);
    txn(1'b0, 12'h180, 32'h0, 32'h0E000000);
    txn(1'b0, 12'h300, 32'h0, 32'h0F000000);
    txn(1'b0, 12'h333, 32'h0, 32'h0F000033);

    // Writes: zero response, one select pulse carrying we and the offset.
    c2 = cs_count[2]; c3 = cs_count[3];
    txn(1'b1, 12'h023, 32'h9, 32'h0);
    chk("cookie_cs_pulses", cs_count[2] - c2, 32'd1);
    chk("cookie_we",   {31'h0, last_we[2]}, 32'h1);
    chk("cookie_addr", {24'h0, last_addr[2]}, 32'h03);
    txn(1'b1, 12'h082, 32'hE, 32'h0);
    chk("keymem_cs_pulses", cs_count[3] - c3, 32'd1);
    chk("keymem_we",   {31'h0, last_we[3]}, 32'h1);
    chk("keymem_addr", {24'h0, last_addr[3]}, 32'h02);

    // Parser RAM fill and readback over the full offset range.
    for (int i = 0; i < 256; i++) begin
      v = 32'h7FFFFFFF + 32'd17 * 32'(i);
      txn(1'b1, 12'h200 + 12'(i), v, 32'h0);
    end
    for (int i = 0; i < 256; i++) begin
      v = 32'h7FFFFFFF + 32'd17 * 32'(i);
      txn(1'b0, 12'h200 + 12'(i), 32'h0, v);
    end

    // Unmapped hole between cookie and keymem.
    total = 0;
    for (int k = 0; k < 7; k++) total += cs_count[k];
    txn(1'b0, 12'h040, 32'h0, 32'h0);
    c2 = 0;
    for (int k = 0; k < 7; k++) c2 += cs_count[k];
    chk("unmapped_no_cs", c2 - total, 32'd0);

    // Reset while in ACCESS aborts without a valid pulse.
    @(negedge clk);
    ext_cs = 1'b1; ext_we = 1'b0; ext_addr = 12'h001;
    @(negedge clk);
    ext_cs = 1'b0;
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",  {31'h0, busy}, 32'h0);
    chk("abort_valid", {31'h0, ext_valid}, 32'h0);
    chk("abort_rdata", ext_rdata, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_valid", {31'h0, ext_valid}, 32'h0);

    // Back to normal operation after the abort.
    txn(1'b0, 12'h01F, 32'h0, 32'h0B00000F);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
